motorchannelctl: RTL and testbench

Host-side controller for one brushed DC motor channel. It sits between the 8-bit host register bus and the motor channel. It holds the channel configuration: run, PWM enable, PWM polarity, tach phase. It generates the tach-filter and PWM-count clock enables from programmable dividers, sequences PWM duty loads, and runs the freeze handshake so a 16-bit tach count reads atomically as two bytes. A watchdog brakes the motor if the host stops refreshing the duty.

---
 rtl/motorctl_pkg.sv | 29 ++
 rtl/cediv.sv | 26 ++
 rtl/motorchannelctl.sv | 201 ++++++++++++++++++++
 tb/tb_motorchannelctl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motorctl_pkg.sv
// Shared definitions for the motor channel controller: register map,
// CTRL/STATUS bit positions and the freeze handshake state type.
package motorctl_pkg;

    localparam logic [2:0] ADDR_DUTY      = 3'd0;
    localparam logic [2:0] ADDR_CTRL      = 3'd1;
    localparam logic [2:0] ADDR_FILTDIV   = 3'd2;
    localparam logic [2:0] ADDR_PWMDIV    = 3'd3;
    localparam logic [2:0] ADDR_COUNTL    = 3'd4;
    localparam logic [2:0] ADDR_COUNTH    = 3'd5;
    localparam logic [2:0] ADDR_WDTRELOAD = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_ENPWM  = 1;
    localparam int CTRL_INVPWM = 2;
    localparam int CTRL_INVPH  = 3;
    localparam int CTRL_WDTEN  = 4;

    localparam int STAT_FREEZE  = 0;
    localparam int STAT_WDTTRIP = 1;
    localparam int STAT_FRZTO   = 2;

    typedef enum logic {
        FRZ_IDLE   = 1'b0,
        FRZ_FROZEN = 1'b1
    } frz_state_t;

endpackage

// File: rtl/cediv.sv
// 8-bit programmable clock-enable divider: ce is high one clock in every
// div+1. restart zeroes the count so the next pulse lands div+1 clocks later.
module cediv (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] div,
    input  logic       restart,
    output logic       ce
);

    logic [7:0] cnt;

    // >= rather than == so a stale count above a new divisor cannot stall
    assign ce = (cnt >= div);

    // count up to the divisor, wrap on the enable, zero on restart
    always_ff @(posedge clk) begin
        if (reset || restart)
            cnt <= 8'd0;
        else if (ce)
            cnt <= 8'd0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/motorchannelctl.sv
// Host-side controller for one brushed DC motor channel: configuration
// registers, clock-enable dividers, PWM duty load, atomic tach-count read
// via the freeze handshake, and a duty-refresh watchdog.
module motorchannelctl
    import motorctl_pkg::*;
#(
    parameter int WDT_PRESC   = 10,
    parameter int FRZ_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic [7:0] wrtdata,
    input  logic       wr,
    input  logic       rd,
    output logic [7:0] rddata,
    input  logic [7:0] countl,
    input  logic [7:0] counth,
    output logic       filterce,
    output logic       pwmcntce,
    output logic       pwmldce,
    output logic [7:0] pwmdata,
    output logic       freeze,
    output logic       invphase,
    output logic       invertpwm,
    output logic       enablepwm,
    output logic       run
);

    // freeze lasts exactly FRZ_TIMEOUT clocks, so the counter starts one short
    localparam logic [15:0] TMO_LOAD = 16'((FRZ_TIMEOUT > 0) ? FRZ_TIMEOUT - 1 : 0);

    logic [7:0]           filtdiv, pwmdiv, wdtreload, wdtcnt;
    logic                 wdten, wdttrip, frzto;
    logic [WDT_PRESC-1:0] presc;
    logic [15:0]          tmo, tmo_nx;
    frz_state_t           state, state_nx;
    logic                 frzto_set;

    logic wr_duty, wr_ctrl, wr_filt, wr_pwm, wr_wdtr, wr_stat;
    logic rd_countl, rd_counth;
    logic wdtick, wdreload, wddec, trip;

    assign wr_duty   = wr && (addr == ADDR_DUTY);
    assign wr_ctrl   = wr && (addr == ADDR_CTRL);
    assign wr_filt   = wr && (addr == ADDR_FILTDIV);
    assign wr_pwm    = wr && (addr == ADDR_PWMDIV);
    assign wr_wdtr   = wr && (addr == ADDR_WDTRELOAD);
    assign wr_stat   = wr && (addr == ADDR_STATUS);
    assign rd_countl = rd && (addr == ADDR_COUNTL);
    assign rd_counth = rd && (addr == ADDR_COUNTH);

    // a reload in the same cycle as a tick always wins over the decrement
    assign wdtick   = &presc;
    assign wdreload = wr_duty || (wr_ctrl && wrtdata[CTRL_WDTEN]);
    assign wddec    = wdtick && wdten && run && !wdreload;
    assign trip     = wddec && (wdtcnt <= 8'd1);

    assign freeze = (state == FRZ_FROZEN);

    cediv u_filtdiv (
        .clk     (clk),
        .reset   (reset),
        .div     (filtdiv),
        .restart (wr_filt),
        .ce      (filterce)
    );

    cediv u_pwmdiv (
        .clk     (clk),
        .reset   (reset),
        .div     (pwmdiv),
        .restart (wr_pwm),
        .ce      (pwmcntce)
    );

    // configuration registers; a watchdog trip overrides a concurrent run write
    always_ff @(posedge clk) begin
        if (reset) begin
            run       <= 1'b0;
            enablepwm <= 1'b0;
            invertpwm <= 1'b0;
            invphase  <= 1'b0;
            wdten     <= 1'b0;
            filtdiv   <= 8'd0;
            pwmdiv    <= 8'd0;
            wdtreload <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                run       <= wrtdata[CTRL_RUN];
                enablepwm <= wrtdata[CTRL_ENPWM];
                invertpwm <= wrtdata[CTRL_INVPWM];
                invphase  <= wrtdata[CTRL_INVPH];
                wdten     <= wrtdata[CTRL_WDTEN];
            end
            if (trip)
                run <= 1'b0;
            if (wr_filt)
                filtdiv <= wrtdata;
            if (wr_pwm)
                pwmdiv <= wrtdata;
            if (wr_wdtr)
                wdtreload <= wrtdata;
        end
    end

    // duty register and the one-cycle load pulse that follows a DUTY write
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmdata <= 8'd0;
            pwmldce <= 1'b0;
        end else begin
            pwmldce <= wr_duty;
            if (wr_duty)
                pwmdata <= wrtdata;
        end
    end

    // watchdog prescaler and down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            presc  <= '0;
            wdtcnt <= 8'd0;
        end else begin
            presc <= presc + 1'b1;
            if (wdreload)
                wdtcnt <= wdtreload;
            else if (wddec)
                wdtcnt <= (wdtcnt <= 8'd1) ? 8'd0 : wdtcnt - 8'd1;
        end
    end

    // sticky status flags: a new set beats a write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            wdttrip <= 1'b0;
            frzto   <= 1'b0;
        end else begin
            wdttrip <= (wdttrip && !(wr_stat && wrtdata[STAT_WDTTRIP])) || trip;
            frzto   <= (frzto && !(wr_stat && wrtdata[STAT_FRZTO])) || frzto_set;
        end
    end

    // freeze FSM state and timeout register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FRZ_IDLE;
            tmo   <= 16'd0;
        end else begin
            state <= state_nx;
            tmo   <= tmo_nx;
        end
    end

    // freeze FSM next state: COUNTH read releases, COUNTL read (re)arms
    always_comb begin
        state_nx  = state;
        tmo_nx    = tmo;
        frzto_set = 1'b0;
        case (state)
            FRZ_IDLE: begin
                if (rd_countl) begin
                    state_nx = FRZ_FROZEN;
                    tmo_nx   = TMO_LOAD;
                end
            end
            FRZ_FROZEN: begin
                if (rd_counth) begin
                    state_nx = FRZ_IDLE;
                end else if (rd_countl) begin
                    tmo_nx = TMO_LOAD;
                end else if (tmo == 16'd0) begin
                    state_nx  = FRZ_IDLE;
                    frzto_set = 1'b1;
                end else begin
                    tmo_nx = tmo - 16'd1;
                end
            end
            default: state_nx = FRZ_IDLE;
        endcase
    end

    // registered read mux; rddata holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rddata <= 8'd0;
        end else if (rd) begin
            case (addr)
                ADDR_CTRL:      rddata <= {3'b000, wdten, invphase, invertpwm, enablepwm, run};
                ADDR_FILTDIV:   rddata <= filtdiv;
                ADDR_PWMDIV:    rddata <= pwmdiv;
                ADDR_COUNTL:    rddata <= countl;
                ADDR_COUNTH:    rddata <= counth;
                ADDR_WDTRELOAD: rddata <= wdtreload;
                ADDR_STATUS:    rddata <= {5'b00000, frzto, wdttrip, freeze};
                default:        rddata <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_motorchannelctl.sv
// Bench for motorchannelctl: register vectors from a table, then directed
// sequences for dividers, freeze handshake/timeout, watchdog and reset.
module tb_motorchannelctl;
    import motorctl_pkg::*;

    localparam int PRESC = 4;
    localparam int FRZTO = 16;

    logic       clk = 1'b0;
    logic       reset, wr, rd;
    logic [2:0] addr;
    logic [7:0] wrtdata, rddata, countl, counth, pwmdata;
    logic       filterce, pwmcntce, pwmldce, freeze, invphase, invertpwm, enablepwm, run;

    logic [15:0] live_cnt;
    logic [15:0] frz_cnt = 16'd0;

    int errors = 0;
    int checks = 0;

    motorchannelctl #(.WDT_PRESC(PRESC), .FRZ_TIMEOUT(FRZTO)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrtdata(wrtdata), .wr(wr), .rd(rd),
        .rddata(rddata), .countl(countl), .counth(counth), .filterce(filterce),
        .pwmcntce(pwmcntce), .pwmldce(pwmldce), .pwmdata(pwmdata), .freeze(freeze),
        .invphase(invphase), .invertpwm(invertpwm), .enablepwm(enablepwm), .run(run)
    );

    always #5 clk = ~clk;

    // channel model: holds its count while freeze is high
    always @(posedge clk) if (!freeze) frz_cnt <= live_cnt;
    assign countl = freeze ? frz_cnt[7:0]  : live_cnt[7:0];
    assign counth = freeze ? frz_cnt[15:8] : live_cnt[15:8];

    typedef struct {
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr;
        logic [7:0] exp_rd;
        logic [3:0] exp_ctl;   // {invphase, invertpwm, enablepwm, run}
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wrtdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rddata;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int n;
        int ok;

        vecs[0] = '{ADDR_CTRL,      8'h0E, ADDR_CTRL,      8'h0E, 4'b1110};
        vecs[1] = '{ADDR_CTRL,      8'hE7, ADDR_CTRL,      8'h07, 4'b0111};
        vecs[2] = '{ADDR_FILTDIV,   8'h05, ADDR_FILTDIV,   8'h05, 4'b0111};
        vecs[3] = '{ADDR_PWMDIV,    8'h07, ADDR_PWMDIV,    8'h07, 4'b0111};
        vecs[4] = '{ADDR_WDTRELOAD, 8'hA5, ADDR_WDTRELOAD, 8'hA5, 4'b0111};
        vecs[5] = '{ADDR_DUTY,      8'h5A, ADDR_DUTY,      8'h00, 4'b0111};
        vecs[6] = '{ADDR_COUNTH,    8'h99, ADDR_COUNTH,    8'hAB, 4'b0111};
        vecs[7] = '{ADDR_STATUS,    8'hFF, ADDR_STATUS,    8'h00, 4'b0111};
        vecs[8] = '{ADDR_CTRL,      8'h00, ADDR_CTRL,      8'h00, 4'b0000};

        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = 3'd0; wrtdata = 8'd0; live_cnt = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_rddata", rddata, 8'h00);
        chk("rst_pwmdata", pwmdata, 8'h00);
        chk("rst_ctl", {3'b000, freeze, invphase, invertpwm, enablepwm, run}, 8'h00);
        chk1("rst_pwmldce", pwmldce, 1'b0);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (!(filterce && pwmcntce)) ok = 0;
            @(negedge clk);
        end
        chk1("rst_ce_continuous", ok[0], 1'b1);
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), r);
            chk($sformatf("rst_read_%0d", a), r, 8'h00);
        end

        // table-driven register vectors
        live_cnt = 16'hAB34;
        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata);
            chk($sformatf("vec%0d_ctl", i), {4'b0000, invphase, invertpwm, enablepwm, run},
                {4'b0000, vecs[i].exp_ctl});
            do_read(vecs[i].raddr, r);
            chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
        end
        chk("vec_duty_pwmdata", pwmdata, 8'h5A);
        chk1("vec_freeze_idle", freeze, 1'b0);

        // simultaneous read and write of CTRL: read sees the old value
        @(negedge clk);
        addr = ADDR_CTRL; wrtdata = 8'h06; wr = 1'b1; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("rdwr_rddata", rddata, 8'h00);
        chk("rdwr_ctl", {4'b0000, invphase, invertpwm, enablepwm, run}, 8'h06);
        do_write(ADDR_CTRL, 8'h00);

        // FILTDIV=3: one enable in four, first one 4 clocks after the write
        do_write(ADDR_FILTDIV, 8'd3);
        for (int k = 1; k <= 12; k++) begin
            chk1($sformatf("filtce_k%0d", k), filterce, (k % 4) == 0);
            @(negedge clk);
        end
        do_write(ADDR_PWMDIV, 8'd0);
        ok = 1;
        for (int k = 0; k < 10; k++) begin
            if (!pwmcntce) ok = 0;
            @(negedge clk);
        end
        chk1("pwmce_div0_continuous", ok[0], 1'b1);

        // atomic 16-bit read through freeze
        live_cnt = 16'h12FF;
        do_read(ADDR_COUNTL, r);
        chk("frz_countl", r, 8'hFF);
        chk1("frz_set", freeze, 1'b1);
        live_cnt = 16'h1300;
        @(negedge clk);
        chk1("frz_held", freeze, 1'b1);
        do_read(ADDR_COUNTH, r);
        chk("frz_counth", r, 8'h12);
        chk1("frz_released", freeze, 1'b0);
        do_read(ADDR_STATUS, r);
        chk("frz_status_clean", r, 8'h00);

        // freeze timeout, with one re-arming COUNTL read
        do_read(ADDR_COUNTL, r);
        chk("tmo_countl", r, 8'h00);
        repeat (8) @(negedge clk);
        do_read(ADDR_COUNTL, r);
        n = 0;
        while (freeze && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_length", 8'(n), 8'(FRZTO));
        do_read(ADDR_STATUS, r);
        chk("tmo_status", r, 8'h04);
        do_write(ADDR_STATUS, 8'h04);
        do_read(ADDR_STATUS, r);
        chk("tmo_status_cleared", r, 8'h00);

        // watchdog trip after two ticks
        do_write(ADDR_WDTRELOAD, 8'd2);
        do_write(ADDR_CTRL, 8'h13);
        repeat (1 << PRESC) @(negedge clk);
        chk1("wdt_run_before", run, 1'b1);
        n = 0;
        while (run && n < (1 << PRESC) + 4) begin
            n++;
            @(negedge clk);
        end
        chk1("wdt_tripped", run, 1'b0);
        chk1("wdt_enpwm_kept", enablepwm, 1'b1);
        do_read(ADDR_STATUS, r);
        chk("wdt_status", r, 8'h02);
        do_read(ADDR_CTRL, r);
        chk("wdt_ctrl", r, 8'h12);
        do_write(ADDR_STATUS, 8'h02);
        do_read(ADDR_STATUS, r);
        chk("wdt_status_cleared", r, 8'h00);

        // refreshing the duty keeps the watchdog from tripping
        do_write(ADDR_CTRL, 8'h13);
        for (int i = 0; i < 10; i++) begin
            do_write(ADDR_DUTY, 8'(8'h10 + i));
            chk1($sformatf("ld_pulse_%0d", i), pwmldce, 1'b1);
            chk($sformatf("ld_data_%0d", i), pwmdata, 8'(8'h10 + i));
            @(negedge clk);
            chk1($sformatf("ld_pulse_end_%0d", i), pwmldce, 1'b0);
            repeat (5) @(negedge clk);
        end
        chk1("refresh_run", run, 1'b1);
        do_write(ADDR_CTRL, 8'h00);

        // reload of 1 with a DUTY write every cycle: every tick coincides with a write
        do_write(ADDR_WDTRELOAD, 8'd1);
        @(negedge clk);
        addr = ADDR_CTRL; wrtdata = 8'h13; wr = 1'b1;
        @(negedge clk);
        addr = ADDR_DUTY; wrtdata = 8'h77;
        repeat (40) @(negedge clk);
        wr = 1'b0;
        chk1("coinc_run", run, 1'b1);
        chk("coinc_pwmdata", pwmdata, 8'h77);
        do_read(ADDR_STATUS, r);
        chk("coinc_status", r, 8'h00);
        do_write(ADDR_CTRL, 8'h00);

        // reset in FROZEN drops freeze on the next edge
        do_write(ADDR_CTRL, 8'h0F);
        do_read(ADDR_COUNTL, r);
        chk1("rstfrz_frozen", freeze, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("rstfrz_freeze", freeze, 1'b0);
        chk("rstfrz_ctl", {4'b0000, invphase, invertpwm, enablepwm, run}, 8'h00);
        chk("rstfrz_rddata", rddata, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
